// File: rtl/nqueen_pkg.sv
// Shared definitions for the N-Queens CFU and its autonomous sequencer:
// CFU function ids and the sequencer state encoding.
package nqueen_pkg;

  localparam int FID_W = 10;

  localparam logic [FID_W-1:0] FN_INIT    = 10'd0;
  localparam logic [FID_W-1:0] FN_KERNEL  = 10'd1;
  localparam logic [FID_W-1:0] FN_GET_RET = 10'd2;
  localparam logic [FID_W-1:0] FN_GET_PC  = 10'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_KERNEL,
    S_GETRET,
    S_NEXT
  } seq_state_t;

endpackage

// File: rtl/next_col_pe.sv
// Combinational next-column finder: lowest set bit of mask strictly above
// col, or the lowest set bit overall when first is high.
module next_col_pe #(
  parameter int N_COLS = 16,
  parameter int COL_W  = 5
) (
  input  logic [N_COLS-1:0] mask,
  input  logic [COL_W-1:0]  col,
  input  logic              first,
  output logic              found,
  output logic [COL_W-1:0]  idx
);

  logic [N_COLS-1:0] cand;

  // Knock out bits at or below col, then priority-encode from the bottom.
  always_comb begin
    cand = mask;
    for (int i = 0; i < N_COLS; i++)
      if (!first && COL_W'(i) <= col) cand[i] = 1'b0;
    found = |cand;
    idx   = '0;
    for (int i = N_COLS - 1; i >= 0; i--)
      if (cand[i]) idx = COL_W'(i);
  end

endmodule

// File: rtl/nqueen_cfu_sequencer.sv
// Autonomous CFU master for the N-Queens search. For every set bit of
// col_mask it issues INIT(col), KERNEL until the CFU reports finished,
// then GET_RET, accumulating the per-column counts into total.
// Optional: NQUEEN_SEQ_PERF_EN adds perf_cycles / perf_kernels counters.
module nqueen_cfu_sequencer
  import nqueen_pkg::*;
#(
  parameter int N_COLS = 16,
  parameter int COL_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [N_COLS-1:0] col_mask,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [31:0]       total,
  output logic [COL_W-1:0]  cur_col,
  output logic              cfu_cmd_valid,
  input  logic              cfu_cmd_ready,
  output logic [FID_W-1:0]  cfu_cmd_function_id,
  output logic [31:0]       cfu_cmd_inputs_0,
  output logic [31:0]       cfu_cmd_inputs_1,
  output logic [31:0]       cfu_cmd_inputs_2,
  input  logic              cfu_rsp_valid,
  output logic              cfu_rsp_ready,
  input  logic [31:0]       cfu_rsp_outputs_0
`ifdef NQUEEN_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_kernels
`endif
);

  seq_state_t        state;
  logic [N_COLS-1:0] mask_q;
  logic [N_COLS-1:0] pe_mask;
  logic              pe_found;
  logic [COL_W-1:0]  pe_idx;
  logic              in_idle;
  logic              xfer;

  // The CFU answers in the same cycle it accepts a command, so a transfer
  // needs both handshakes together.
  assign xfer          = cfu_cmd_valid & cfu_cmd_ready & cfu_rsp_valid;
  assign cfu_rsp_ready = cfu_cmd_valid;
  assign in_idle       = (state == S_IDLE);

  // Only INIT carries an argument; fid and cur_col are registers, so the
  // command fields cannot move while a command is pending.
  assign cfu_cmd_inputs_0 = (cfu_cmd_function_id == FN_INIT) ? 32'(cur_col) : 32'd0;
  assign cfu_cmd_inputs_1 = 32'd0;
  assign cfu_cmd_inputs_2 = 32'd0;

  // In IDLE search the incoming mask from bit 0; otherwise search the
  // latched mask above the current column.
  assign pe_mask = in_idle ? col_mask : mask_q;

  next_col_pe #(.N_COLS(N_COLS), .COL_W(COL_W)) u_next_col (
    .mask  (pe_mask),
    .col   (cur_col),
    .first (in_idle),
    .found (pe_found),
    .idx   (pe_idx)
  );

  // Sequencer FSM with registered outputs; abort overrides the normal
  // transition but a transfer completing in the same cycle still lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= S_IDLE;
      mask_q              <= '0;
      cur_col             <= '0;
      total               <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      aborted             <= 1'b0;
      cfu_cmd_valid       <= 1'b0;
      cfu_cmd_function_id <= FN_INIT;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          mask_q  <= col_mask;
          total   <= '0;
          aborted <= 1'b0;
          busy    <= 1'b1;
          if (pe_found) begin
            cur_col             <= pe_idx;
            cfu_cmd_function_id <= FN_INIT;
            cfu_cmd_valid       <= 1'b1;
            state               <= S_INIT;
          end else begin
            cur_col <= '0;
            state   <= S_NEXT;
          end
        end
        S_INIT: if (xfer) begin
          cfu_cmd_function_id <= FN_KERNEL;
          state               <= S_KERNEL;
        end
        S_KERNEL: if (xfer && cfu_rsp_outputs_0 == 32'd0) begin
          cfu_cmd_function_id <= FN_GET_RET;
          state               <= S_GETRET;
        end
        S_GETRET: if (xfer) begin
          total         <= total + cfu_rsp_outputs_0;
          cfu_cmd_valid <= 1'b0;
          state         <= S_NEXT;
        end
        S_NEXT: if (pe_found) begin
          cur_col             <= pe_idx;
          cfu_cmd_function_id <= FN_INIT;
          cfu_cmd_valid       <= 1'b1;
          state               <= S_INIT;
        end else begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (!in_idle && abort) begin
        cfu_cmd_valid <= 1'b0;
        aborted       <= 1'b1;
        busy          <= 1'b0;
        done          <= 1'b1;
        state         <= S_IDLE;
      end
    end
  end

`ifdef NQUEEN_SEQ_PERF_EN
  // Run-scoped counters: busy cycles and completed kernel transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles  <= '0;
      perf_kernels <= '0;
    end else if (in_idle && start) begin
      perf_cycles  <= '0;
      perf_kernels <= '0;
    end else begin
      if (busy) perf_cycles <= perf_cycles + 32'd1;
      if (xfer && state == S_KERNEL) perf_kernels <= perf_kernels + 32'd1;
    end
  end
`endif

endmodule

// File: doc/nqueen_cfu_sequencer.md
# nqueen_cfu_sequencer

Autonomous master for the N-Queens CFU command/response port. It walks a mask of first-row columns and, for each column, issues init, then kernel commands until the search reports finished, then get_ret. It accumulates the per-column solution counts into one total. It sits beside the CPU as an alternative CFU driver, so a whole search runs without per-step software issue.

## Interface
- `N_COLS`, default 16: board size. Must equal the CFU's compiled N.
- `COL_W`, default 5: width of a column index. Requires 2^COL_W ≥ N_COLS.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `abort` in 1: stop after the current CFU transfer.
- `col_mask` in N_COLS: first-row columns to search. Sampled with `start`.
- `busy` out 1: high from `start` acceptance until `done`.
- `done` out 1: one-cycle pulse at end of a run or an abort.
- `aborted` out 1: valid with `done`. Held until the next `start`.
- `total` out 32: sum of counts. Held until the next `start`.
- `cur_col` out COL_W: column being searched.
- `cfu_cmd_valid` out 1, `cfu_cmd_ready` in 1.
- `cfu_cmd_function_id` out 10; `cfu_cmd_inputs_0/1/2` out 32 each.
- `cfu_rsp_valid` in 1, `cfu_rsp_ready` out 1, `cfu_rsp_outputs_0` in 32.

## Operation
- States: IDLE, INIT, KERNEL, GETRET, NEXT.
- A transfer completes in a cycle where `cfu_cmd_valid`, `cfu_cmd_ready` and `cfu_rsp_valid` are all high.
- `cfu_rsp_ready` equals `cfu_cmd_valid` at all times.
- Command fields are held stable while `cfu_cmd_valid` is high and the transfer is not complete.
- `inputs_1` and `inputs_2` are always 0.
- **IDLE**, when `start` is sampled: latch `col_mask`, clear `total`, clear `aborted`.
  - Empty mask: go to NEXT.
  - Otherwise: `cur_col` takes the lowest set bit, then go to INIT.
- **INIT**: issue function 0 with `inputs_0` = `cur_col`. On completion go to KERNEL.
- **KERNEL**: issue function 1 back-to-back, one per completing cycle.
  - On completion with `outputs_0` == 0: go to GETRET.
  - Nonzero: stay in KERNEL.
- **GETRET**: issue function 2. On completion, `total` += `outputs_0` (modulo 2^32), then go to NEXT.
- **NEXT**: find the lowest mask bit above `cur_col`.
  - If found: load it into `cur_col` and go to INIT.
  - If none: pulse `done` and go to IDLE.
  - In the empty-mask case the search starts at bit 0.
- **abort** in any non-IDLE state:
  - Sampled with no transfer completing: drop `cfu_cmd_valid` next cycle, set `aborted`, pulse `done`, go to IDLE.
  - Coinciding with a completing transfer: that transfer's effect (including a `total` update) is kept first.
  - Priority is abort over the normal transition.
- `start` while busy is ignored.
- `start` and `abort` together in IDLE: `start` wins and `abort` is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `aborted`, `cfu_cmd_valid`, `cfu_rsp_ready` all 0.
  - `total` 0, `cur_col` 0, function id 0, all inputs 0.
- Reset mid-run returns to IDLE at once. CFU internal state is not cleared; the next run's INIT re-establishes it.
- `start` sampled on edge k:
  - `busy` and the first INIT `cfu_cmd_valid` are high at k+1.
  - With a zero-wait CFU, column cost = 1 + K + 1 + 1 cycles (K = kernel count).
- `done` pulses the cycle after the last GETRET completion, passing through NEXT.
- Empty mask: `done` at k+2 with `total` = 0.
- `busy` falls in the same cycle `done` is high. `total` is final when `done` is high.

## Configuration
- `NQUEEN_SEQ_PERF_EN` defined:
  - Adds outputs `perf_cycles` (32) and `perf_kernels` (32).
  - Both clear on `start` and hold after `done`.
  - `perf_cycles` counts cycles with `busy` high.
  - `perf_kernels` counts completed function-1 transfers.
  - Both wrap modulo 2^32.
- Undefined: neither port nor counter logic exists. All other behaviour is identical.

## Structure
- Shared package `nqueen_pkg`:
  - Function IDs `FN_INIT` = 0, `FN_KERNEL` = 1, `FN_GET_RET` = 2, `FN_GET_PC` = 3.
  - State enum.
  - `FID_W` = 10.
- Sub-module `next_col_pe`: combinational lowest-set-bit finder over `mask & ~((2 << col) - 1)`.
  - Has a "first" mode that ignores `col`.
  - Outputs `found` and the index.

## Test plan
- CFU model at N = 4, `N_COLS` = 4, `col_mask` = 0xF, start → `done` with `total` = 2, `aborted` = 0.
- Same model, `col_mask` = 0x2 → `total` = 1; `col_mask` = 0x1 → `total` = 0. Each shows exactly one INIT per set bit, with `inputs_0` equal to the column.
- CFU model at N = 8, `col_mask` = 0xFF → `total` = 92. Function ids seen as INIT, kernels, GETRET per column.
- `cfu_cmd_ready` low for 3 cycles during KERNEL and GETRET → command held stable and counted once; `total` unchanged versus the zero-wait run.
- `col_mask` = 0 → `done` 2 cycles after `start`, `total` = 0, no CFU command issued. Then abort in mid-KERNEL → `done` with `aborted` = 1, `cfu_cmd_valid` low the next cycle.
- `reset` asserted mid-GETRET → all outputs at reset values immediately. A following `start` with `col_mask` = 0xF gives `total` = 2.
